// File: rtl/line_raster_engine.sv
// line_raster_engine: Bresenham line rasteriser for the frame-buffer write path.
// Accepts two arbitrary endpoints, normalises them to a shallow, left-to-right
// line, then steps the major axis one pixel per valid/ready handshake.
// Pixels are always emitted in increasing major-axis order.

module line_raster_engine #(
  parameter int XW = 9,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0_in,
  input  logic [YW-1:0] y0_in,
  input  logic [XW-1:0] x1_in,
  input  logic [YW-1:0] y1_in,
  output logic          busy,
  output logic          done,
  output logic          plot_valid,
  input  logic          plot_ready,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y
);

  // Common internal coordinate width; both axes are zero-extended to it so a
  // steep swap can move an x value into the y slot without losing bits.
  localparam int CW = (XW > YW) ? XW : YW;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] INIT  = 3'd2;
  localparam logic [2:0] DRAW  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]           state;

  // Command endpoints as latched in IDLE.
  logic [CW-1:0]        lx0, ly0, lx1, ly1;

  // Normalised endpoints: a = major axis, b = minor axis, a0 <= a1.
  logic                 steep;
  logic [CW-1:0]        ea0, eb0, ea1, eb1;

  // Bresenham working state.
  logic [CW:0]          dx, dy;
  logic signed [CW+1:0] err;
  logic                 ystep_neg;
  logic [CW-1:0]        cx, cy;

  logic                 handshake;

  // Setup-stage combinational values.
  logic [CW:0]          abs_dx_c, abs_dy_c;
  logic                 steep_c;
  logic [CW-1:0]        a0_c, b0_c, a1_c, b1_c;
  logic [CW-1:0]        sa0_c, sb0_c, sa1_c, sb1_c;

  // Init-stage combinational values.
  logic [CW:0]          dx_c, dy_c;
  logic signed [CW+1:0] err_init_c;

  // Draw-stage next-pixel values.
  logic signed [CW+1:0] err_dy_c, err_nxt_c;
  logic [CW-1:0]        cx_nxt_c, cy_nxt_c;

  assign handshake = plot_valid && plot_ready;

  // Octant normalisation: decide steepness, swap axes, then order endpoints.
  always_comb begin
    // NOTE: every variable gets a value on every path, otherwise always_comb
    // would infer a latch to hold the old value.
    abs_dx_c = (lx1 >= lx0) ? ({1'b0, lx1} - {1'b0, lx0})
                            : ({1'b0, lx0} - {1'b0, lx1});
    abs_dy_c = (ly1 >= ly0) ? ({1'b0, ly1} - {1'b0, ly0})
                            : ({1'b0, ly0} - {1'b0, ly1});
    steep_c  = abs_dy_c > abs_dx_c;

    a0_c = steep_c ? ly0 : lx0;
    b0_c = steep_c ? lx0 : ly0;
    a1_c = steep_c ? ly1 : lx1;
    b1_c = steep_c ? lx1 : ly1;

    sa0_c = a0_c;
    sb0_c = b0_c;
    sa1_c = a1_c;
    sb1_c = b1_c;
    if (a0_c > a1_c) begin
      sa0_c = a1_c;
      sb0_c = b1_c;
      sa1_c = a0_c;
      sb1_c = b0_c;
    end
  end

  // Deltas and initial error term from the normalised endpoints.
  always_comb begin
    dx_c       = {1'b0, ea1} - {1'b0, ea0};
    dy_c       = (eb1 >= eb0) ? ({1'b0, eb1} - {1'b0, eb0})
                              : ({1'b0, eb0} - {1'b0, eb1});
    err_init_c = -$signed({1'b0, dx_c >> 1});
  end

  // One Bresenham step: advance major axis, step minor axis when the
  // accumulated error reaches zero.
  always_comb begin
    err_dy_c  = err + $signed({1'b0, dy});
    cx_nxt_c  = cx + CW'(1);
    cy_nxt_c  = cy;
    err_nxt_c = err_dy_c;
    if (!err_dy_c[CW+1]) begin
      cy_nxt_c  = ystep_neg ? (cy - CW'(1)) : (cy + CW'(1));
      err_nxt_c = err_dy_c - $signed({1'b0, dx});
    end
  end

  // Control FSM and datapath registers; outputs are registered so they stay
  // stable while the pixel writer stalls.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      plot_valid <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      lx0        <= '0;
      ly0        <= '0;
      lx1        <= '0;
      ly1        <= '0;
      steep      <= 1'b0;
      ea0        <= '0;
      eb0        <= '0;
      ea1        <= '0;
      eb1        <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      ystep_neg  <= 1'b0;
      cx         <= '0;
      cy         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lx0   <= CW'(x0_in);
            ly0   <= CW'(y0_in);
            lx1   <= CW'(x1_in);
            ly1   <= CW'(y1_in);
            busy  <= 1'b1;
            state <= SETUP;
          end
        end

        SETUP: begin
          steep <= steep_c;
          ea0   <= sa0_c;
          eb0   <= sb0_c;
          ea1   <= sa1_c;
          eb1   <= sb1_c;
          state <= INIT;
        end

        INIT: begin
          dx         <= dx_c;
          dy         <= dy_c;
          err        <= err_init_c;
          ystep_neg  <= !(eb0 < eb1);
          cx         <= ea0;
          cy         <= eb0;
          plot_x     <= XW'(steep ? eb0 : ea0);
          plot_y     <= YW'(steep ? ea0 : eb0);
          plot_valid <= 1'b1;
          state      <= DRAW;
        end

        DRAW: begin
          if (handshake) begin
            if (cx == ea1) begin
              plot_valid <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              cx     <= cx_nxt_c;
              cy     <= cy_nxt_c;
              err    <= err_nxt_c;
              plot_x <= XW'(steep ? cy_nxt_c : cx_nxt_c);
              plot_y <= YW'(steep ? cx_nxt_c : cy_nxt_c);
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy       <= 1'b0;
          done       <= 1'b0;
          plot_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// tb_line_raster_engine: scoreboard bench for line_raster_engine.
// Expected pixels are queued when a command is issued and popped by a
// negedge monitor on each valid/ready handshake.

module tb_line_raster_engine;

  localparam int XW = 9;
  localparam int YW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [XW-1:0] x0_in, x1_in;
  logic [YW-1:0] y0_in, y1_in;
  logic          busy, done, plot_valid, plot_ready;
  logic [XW-1:0] plot_x;
  logic [YW-1:0] plot_y;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int hs_cnt = 0;

  logic        stall_prev = 1'b0;
  logic        hs_prev    = 1'b0;
  logic [31:0] held_px    = '0;

  always #5 clk = ~clk;

  line_raster_engine #(.XW(XW), .YW(YW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x0_in      (x0_in),
    .y0_in      (y0_in),
    .x1_in      (x1_in),
    .y1_in      (y1_in),
    .busy       (busy),
    .done       (done),
    .plot_valid (plot_valid),
    .plot_ready (plot_ready),
    .plot_x     (plot_x),
    .plot_y     (plot_y)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pk(input int x, input int y);
    return ((x & 511) << 8) | (y & 255);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic push_px(input int x, input int y);
    exp_q.push_back(pk(x, y));
  endtask

  // Reference Bresenham in plain integers.
  task automatic push_model(input int x0, input int y0, input int x1, input int y1);
    int t, dx, dy, err, ys, x, y;
    bit st;
    st = iabs(y1 - y0) > iabs(x1 - x0);
    if (st) begin
      t = x0; x0 = y0; y0 = t;
      t = x1; x1 = y1; y1 = t;
    end
    if (x0 > x1) begin
      t = x0; x0 = x1; x1 = t;
      t = y0; y0 = y1; y1 = t;
    end
    dx  = x1 - x0;
    dy  = iabs(y1 - y0);
    err = -(dx / 2);
    ys  = (y0 < y1) ? 1 : -1;
    x   = x0;
    y   = y0;
    for (int k = 0; k <= dx; k++) begin
      exp_q.push_back(st ? pk(y, x) : pk(x, y));
      x++;
      if (err + dy >= 0) begin
        y   += ys;
        err += dy - dx;
      end else begin
        err += dy;
      end
    end
  endtask

  // Scoreboard monitor: compares handshaked pixels, hold stability and done.
  always @(negedge clk) begin
    if (!reset) begin
      if (stall_prev) begin
        check("hold_valid", {31'b0, plot_valid}, 32'd1);
        check("hold_pixel", {15'b0, plot_x, plot_y}, held_px);
      end
      if (plot_valid && plot_ready) begin
        check("pixel_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0)
          check("pixel", {15'b0, plot_x, plot_y}, exp_q.pop_front());
        hs_cnt++;
      end
      if (done) begin
        check("done_after_hs", {31'b0, hs_prev}, 32'd1);
        check("done_q_empty", exp_q.size(), 32'd0);
        check("done_busy", {31'b0, busy}, 32'd1);
        check("done_no_valid", {31'b0, plot_valid}, 32'd0);
      end
      stall_prev = plot_valid && !plot_ready;
      hs_prev    = plot_valid && plot_ready;
      held_px    = {15'b0, plot_x, plot_y};
    end else begin
      stall_prev = 1'b0;
      hs_prev    = 1'b0;
    end
  end

  // Issue one command and step until done; bp toggles plot_ready, restart
  // pulses start again while the engine is busy.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input bit bp, input bit restart);
    int cyc;
    bit fin;
    x0_in = XW'(ax0); y0_in = YW'(ay0);
    x1_in = XW'(ax1); y1_in = YW'(ay1);
    plot_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check("busy_rise", {31'b0, busy}, 32'd1);
    // Inputs changed after acceptance must not affect the line.
    x0_in = '1; y0_in = 8'd3; x1_in = 9'd2; y1_in = '1;
    fin = 1'b0;
    while (!fin && cyc < 3000) begin
      plot_ready = bp ? cyc[0] : 1'b1;
      if (restart) start = (cyc < 3);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) check("lat_no_valid_yet", {31'b0, plot_valid}, 32'd0);
      if (cyc == 3) check("lat_first_valid", {31'b0, plot_valid}, 32'd1);
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    check("line_finished", {31'b0, fin}, 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("busy_fall", {31'b0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    if (restart) begin
      repeat (4) @(posedge clk);
      #1;
      check("restart_ignored_busy", {31'b0, busy}, 32'd0);
      check("restart_ignored_valid", {31'b0, plot_valid}, 32'd0);
    end
  endtask

  initial begin
    int base, cyc;
    reset = 1'b1; start = 1'b0; plot_ready = 1'b0;
    x0_in = '0; y0_in = '0; x1_in = '0; y1_in = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_valid", {31'b0, plot_valid}, 32'd0);
    check("rst_xy", {15'b0, plot_x, plot_y}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Shallow line.
    push_px(0, 0); push_px(1, 1); push_px(2, 1); push_px(3, 2); push_px(4, 2);
    run_line(0, 0, 4, 2, 1'b0, 1'b0);

    // Steep line.
    push_px(0, 0); push_px(1, 1); push_px(1, 2); push_px(1, 3);
    run_line(0, 0, 1, 3, 1'b0, 1'b0);

    // Reversed endpoints: same pixels, same order.
    push_px(0, 0); push_px(1, 1); push_px(2, 1); push_px(3, 2); push_px(4, 2);
    run_line(4, 2, 0, 0, 1'b0, 1'b0);

    // Negative slope.
    push_px(0, 3); push_px(1, 2); push_px(2, 1); push_px(3, 0);
    run_line(0, 3, 3, 0, 1'b0, 1'b0);

    // Backpressure on the shallow line.
    push_px(0, 0); push_px(1, 1); push_px(2, 1); push_px(3, 2); push_px(4, 2);
    run_line(0, 0, 4, 2, 1'b1, 1'b0);

    // Single point with a second start while busy.
    push_px(7, 5);
    run_line(7, 5, 7, 5, 1'b0, 1'b1);

    // Assorted lines against the reference model.
    for (int i = 0; i < 6; i++) begin
      int ax0, ay0, ax1, ay1;
      ax0 = $urandom_range(0, 511); ay0 = $urandom_range(0, 255);
      ax1 = $urandom_range(0, 511); ay1 = $urandom_range(0, 255);
      push_model(ax0, ay0, ax1, ay1);
      run_line(ax0, ay0, ax1, ay1, i[0], 1'b0);
    end

    // Full-range line interrupted by reset after 100 pixels.
    push_model(0, 0, 511, 255);
    base = hs_cnt;
    x0_in = '0; y0_in = '0; x1_in = 9'd511; y1_in = 8'd255;
    plot_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while ((hs_cnt - base) < 100 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pixels_before_reset", hs_cnt - base, 32'd100);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, plot_valid}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle_valid", {31'b0, plot_valid}, 32'd0);
    check("post_rst_idle_done", {31'b0, done}, 32'd0);

    // Full-range line after reset, ending at (511,255).
    push_model(0, 0, 511, 255);
    check("extreme_len", exp_q.size(), 32'd512);
    check("extreme_last", exp_q[$], pk(511, 255));
    run_line(0, 0, 511, 255, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_raster_engine.md
Name: line_raster_engine

Overview:
Bresenham line rasteriser that accepts two arbitrary endpoints and streams one pixel coordinate per accepted handshake to a downstream pixel writer (VGA frame-buffer adapter). All octants are supported: steep lines, reversed endpoints and negative slope. Coordinate widths are parametrised, and the output has valid/ready backpressure. It replaces the fixed-origin, non-handshaked line datapath and sits between the drawing-command FSM and the frame-buffer write port.

Parameters:
XW, 9, width of x coordinates (x0_in, x1_in, plot_x)
YW, 8, width of y coordinates (y0_in, y1_in, plot_y)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
x0_in  in  XW  start x
y0_in  in  YW  start y
x1_in  in  XW  end x
y1_in  in  YW  end y
busy  out  1  high from command acceptance until the done pulse, inclusive
done  out  1  one-cycle pulse after the last pixel handshake
plot_valid  out  1  plot_x/plot_y hold a pixel
plot_ready  in  1  downstream accepts the pixel when high together with plot_valid
plot_x  out  XW  pixel x
plot_y  out  YW  pixel y

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values: state=IDLE; busy, done, plot_valid, plot_x, plot_y and all internal registers = 0.
- Internal width: CW = max(XW,YW). Coordinates are zero-extended to CW. The error register is signed, CW+2 bits. All delta arithmetic is done at CW+1 bits so no overflow occurs.
- States: IDLE -> SETUP -> INIT -> DRAW -> DONE -> IDLE.
- IDLE
  - start=1 latches all four inputs and moves to SETUP.
  - busy rises on the next edge.
- SETUP (1 cycle)
  - steep = |y1-y0| > |x1-x0|.
  - If steep, swap x and y within each endpoint.
  - Then, if the major-axis start > major-axis end, swap the endpoints.
  - Both swaps take effect in this single cycle, computed combinationally from the latched values.
- INIT (1 cycle)
  - dx = x1-x0 (>= 0); dy = |y1-y0|.
  - err = -(dx>>1), arithmetic.
  - ystep = +1 if y0<y1, else -1.
  - Cursor (cx, cy) = (x0, y0).
- DRAW
  - plot_valid=1.
  - plot_x/plot_y = steep ? (cy, cx) : (cx, cy), truncated to XW/YW.
  - Outputs are registered: they must hold stable while plot_valid && !plot_ready.
  - On handshake with cx == x1: go to DONE.
  - Otherwise on handshake: cx += 1. If err+dy >= 0 then cy += ystep and err = err+dy-dx; else err = err+dy.
  - No handshake: all state holds.
- DONE (1 cycle): done=1, plot_valid=0, busy=1 in this cycle, then return to IDLE with busy=0.
- Throughput and latency:
  - Pixel count is dx+1 along the major axis.
  - The first plot_valid appears 3 cycles after the start edge (IDLE->SETUP->INIT->DRAW).
  - With plot_ready held high, one pixel is emitted per cycle.
- Pixel ordering: pixels are always emitted in increasing major-axis order, regardless of command endpoint order.
- Degenerate line (x0=x1, y0=y1): exactly one pixel, then done.
- start while busy: ignored. Input changes after acceptance have no effect.
- Reset mid-line: immediate return to IDLE; no further pixels and no done pulse.
- Endpoints wider than the destination field after a steep swap cannot occur, because outputs are un-swapped before truncation.

Test Plan:
- Shallow line: start (0,0)->(4,2), plot_ready=1 -> pixels (0,0),(1,1),(2,1),(3,2),(4,2) on 5 consecutive cycles beginning 3 cycles after start; done pulses once the cycle after (4,2).
- Steep line: (0,0)->(1,3) -> (0,0),(1,1),(1,2),(1,3).
- Reversed endpoints: (4,2)->(0,0) -> same 5 pixels as the shallow case, same order. Negative slope: (0,3)->(3,0) -> (0,3),(1,2),(2,1),(3,0).
- Backpressure: shallow case with plot_ready low every other cycle -> the same 5 pixels, each held stable while not ready; no duplicate or dropped pixels; done follows the 5th handshake.
- Single point: (7,5)->(7,5) -> exactly one pixel (7,5), then done. A second start pulsed while busy produces no extra pixels.
- Extremes and reset: (0,0)->(511,255) -> 512 pixels, last (511,255). Assert reset after the 100th pixel -> busy, plot_valid and done go to 0 immediately; a new start then draws correctly.
